// File: rtl/masked_split_bv_seq.sv
// Purpose : split one masked 2*HALF_WIDTH-bit word (NUM_SHARES shares) into two half-width masked beats.
// Latency : first beat valid 1 cycle after accept, second beat the cycle after the first is consumed.
// Backpr. : out_ready only in EMPTY or while the last beat is being consumed; held beats stay stable.
//
// Ports:
//   in_clock  - rising-edge clock
//   in_reset  - asynchronous active-low reset
//   in_a      - masked input word, one packed lane per share
//   in_valid  - in_a valid
//   out_ready - block can accept in_a this cycle
//   out_b     - masked half-word beat, one packed lane per share
//   out_half  - 0: out_b carries the low half, 1: the high half
//   out_valid - out_b / out_half valid
//   in_ready  - downstream accepts the beat this cycle
module masked_split_bv_seq #(
    parameter int NUM_SHARES = 2,
    parameter int HALF_WIDTH = 15,
    parameter int HIGH_FIRST = 0
) (
    input  logic                                      in_clock,
    input  logic                                      in_reset,
    input  logic [NUM_SHARES-1:0][2*HALF_WIDTH-1:0]   in_a,
    input  logic                                      in_valid,
    output logic                                      out_ready,
    output logic [NUM_SHARES-1:0][HALF_WIDTH-1:0]     out_b,
    output logic                                      out_half,
    output logic                                      out_valid,
    input  logic                                      in_ready
);

    localparam logic FIRST_HALF = (HIGH_FIRST != 0);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Each share has its own lane in the word register; lanes never mix.
    logic [NUM_SHARES-1:0][2*HALF_WIDTH-1:0] word_q;

    logic accept;
    logic half_sel;

    // Handshake and next-state logic. in_ready only reaches out_ready through
    // the SECOND-state term, which lets a new word land as the last beat leaves.
    always_comb begin
        out_ready = (state == EMPTY) || ((state == SECOND) && in_ready);
        accept    = in_valid && out_ready;
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = FIRST;
                end
            end
            FIRST: begin
                if (in_ready) begin
                    state_nxt = SECOND;
                end
            end
            SECOND: begin
                if (in_ready) begin
                    state_nxt = accept ? FIRST : EMPTY;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            state  <= EMPTY;
            word_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                word_q <= in_a;
            end
        end
    end

    // Half select comes from the state register alone so the mux control is
    // independent of any share value.
    always_comb begin
        out_valid = (state != EMPTY);
        half_sel  = 1'b0;
        out_b     = '0;
        case (state)
            FIRST:   half_sel = FIRST_HALF;
            SECOND:  half_sel = !FIRST_HALF;
            default: half_sel = 1'b0;
        endcase
        out_half = half_sel;
        if (state != EMPTY) begin
            for (int i = 0; i < NUM_SHARES; i++) begin
                out_b[i] = half_sel ? word_q[i][2*HALF_WIDTH-1:HALF_WIDTH]
                                    : word_q[i][HALF_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_masked_split_bv_seq.sv
// Purpose : scoreboard bench for masked_split_bv_seq, low-first and high-first instances side by side.
// Latency : expected beats are queued at accept and popped when the DUT presents a consumed beat.
// Backpr. : in_ready is directed or randomized; held beats must match the queue head every cycle.
module tb_masked_split_bv_seq;

    typedef logic [1:0][29:0] word_t;
    typedef logic [1:0][14:0] half_t;

    logic        in_clock;
    logic        in_reset;
    word_t       in_a;
    logic        in_valid;
    logic        in_ready;

    logic        lo_ready, lo_half, lo_valid;
    half_t       lo_b;
    logic        hi_ready, hi_half, hi_valid;
    half_t       hi_b;

    masked_split_bv_seq #(.NUM_SHARES(2), .HALF_WIDTH(15), .HIGH_FIRST(0)) u_lo (
        .in_clock (in_clock),
        .in_reset (in_reset),
        .in_a     (in_a),
        .in_valid (in_valid),
        .out_ready(lo_ready),
        .out_b    (lo_b),
        .out_half (lo_half),
        .out_valid(lo_valid),
        .in_ready (in_ready)
    );

    masked_split_bv_seq #(.NUM_SHARES(2), .HALF_WIDTH(15), .HIGH_FIRST(1)) u_hi (
        .in_clock (in_clock),
        .in_reset (in_reset),
        .in_a     (in_a),
        .in_valid (in_valid),
        .out_ready(hi_ready),
        .out_b    (hi_b),
        .out_half (hi_half),
        .out_valid(hi_valid),
        .in_ready (in_ready)
    );

    initial in_clock = 1'b0;
    always #5 in_clock = ~in_clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: a beat is {half, per-share slice of that half}.
    function automatic logic [30:0] beat_of(input word_t w, input logic h);
        half_t b;
        for (int i = 0; i < 2; i++) begin
            b[i] = h ? w[i][29:15] : w[i][14:0];
        end
        return {h, b};
    endfunction

    // Pending beats per instance. The model's readiness rule: the block is
    // free when nothing is pending, or when the single remaining beat leaves now.
    logic [30:0] q_lo[$];
    logic [30:0] q_hi[$];
    logic        exp_ready = 1'b0;
    logic        acc_flag  = 1'b0;

    // Monitor: compare whatever the DUTs present against the queue heads.
    always @(negedge in_clock) begin
        if (in_reset) begin
            exp_ready = (q_lo.size() == 0) || ((q_lo.size() == 1) && in_ready);
            chk("lo_out_ready", {63'd0, lo_ready}, {63'd0, exp_ready});
            chk("hi_out_ready", {63'd0, hi_ready}, {63'd0, exp_ready});
            chk("lo_out_valid", {63'd0, lo_valid}, {63'd0, q_lo.size() != 0});
            chk("hi_out_valid", {63'd0, hi_valid}, {63'd0, q_hi.size() != 0});
            if (q_lo.size() != 0 && q_hi.size() != 0) begin
                chk("lo_beat", {33'd0, lo_half, lo_b}, {33'd0, q_lo[0]});
                chk("hi_beat", {33'd0, hi_half, hi_b}, {33'd0, q_hi[0]});
                if (in_ready) begin
                    void'(q_lo.pop_front());
                    void'(q_hi.pop_front());
                end
            end else begin
                chk("lo_idle_beat", {33'd0, lo_half, lo_b}, 64'd0);
                chk("hi_idle_beat", {33'd0, hi_half, hi_b}, 64'd0);
            end
        end
    end

    // Scoreboard feed: a word offered while the model says ready is accepted.
    always @(posedge in_clock) begin
        acc_flag = 1'b0;
        if (in_reset && in_valid && exp_ready) begin
            acc_flag = 1'b1;
            q_lo.push_back(beat_of(in_a, 1'b0));
            q_lo.push_back(beat_of(in_a, 1'b1));
            q_hi.push_back(beat_of(in_a, 1'b1));
            q_hi.push_back(beat_of(in_a, 1'b0));
        end
    end

    logic rnd_rdy = 1'b0;

    task automatic cycle();
        @(posedge in_clock);
        #1;
        if (rnd_rdy) in_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input word_t w);
        int n;
        in_a     = w;
        in_valid = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!acc_flag && n < 50);
        chk("accept_within_budget", {63'd0, acc_flag}, 64'd1);
    endtask

    task automatic rand_word(output word_t w);
        w[0] = 30'($urandom);
        w[1] = 30'($urandom);
    endtask

    word_t w_a, w_b, w_r;
    int    n;

    initial begin
        in_reset = 1'b0;
        in_a     = '0;
        in_valid = 1'b0;
        in_ready = 1'b1;
        repeat (2) @(posedge in_clock);
        #1;
        chk("rst_lo_valid", {63'd0, lo_valid}, 64'd0);
        chk("rst_lo_ready", {63'd0, lo_ready}, 64'd1);
        chk("rst_lo_b",     {33'd0, lo_half, lo_b}, 64'd0);
        chk("rst_hi_valid", {63'd0, hi_valid}, 64'd0);
        in_reset = 1'b1;
        cycle();

        // Single word, both half orders.
        w_a[0] = {15'h1234, 15'h0ABC};
        w_a[1] = {15'h7FFF, 15'h0001};
        send(w_a);
        in_valid = 1'b0;
        chk("t2_lo_beat1", {33'd0, lo_half, lo_b}, {33'd0, 1'b0, 15'h0001, 15'h0ABC});
        chk("t3_hi_beat1", {33'd0, hi_half, hi_b}, {33'd0, 1'b1, 15'h7FFF, 15'h1234});
        cycle();
        chk("t2_lo_beat2", {33'd0, lo_half, lo_b}, {33'd0, 1'b1, 15'h7FFF, 15'h1234});
        chk("t3_hi_beat2", {33'd0, hi_half, hi_b}, {33'd0, 1'b0, 15'h0001, 15'h0ABC});
        cycle();
        chk("t2_lo_done", {63'd0, lo_valid}, 64'd0);
        chk("t3_hi_done", {63'd0, hi_valid}, 64'd0);

        // Backpressure during FIRST with a competing word on the input.
        rand_word(w_a);
        rand_word(w_b);
        send(w_a);
        in_ready = 1'b0;
        in_a     = w_b;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_lo_ready", {63'd0, lo_ready}, 64'd0);
            chk("bp_lo_hold",  {33'd0, lo_half, lo_b}, {33'd0, beat_of(w_a, 1'b0)});
            chk("bp_hi_hold",  {33'd0, hi_half, hi_b}, {33'd0, beat_of(w_a, 1'b1)});
        end
        in_ready = 1'b1;
        send(w_b);
        in_valid = 1'b0;
        repeat (3) cycle();

        // Streaming: four words back to back with in_ready held high.
        for (int k = 0; k < 4; k++) begin
            rand_word(w_r);
            send(w_r);
        end
        in_valid = 1'b0;
        repeat (3) cycle();

        // Reset in the middle of the second beat.
        rand_word(w_a);
        send(w_a);
        in_valid = 1'b0;
        cycle();
        chk("pre_rst_lo_half", {63'd0, lo_half}, 64'd1);
        #2;
        in_reset = 1'b0;
        q_lo.delete();
        q_hi.delete();
        #1;
        chk("mid_rst_lo_valid", {63'd0, lo_valid}, 64'd0);
        chk("mid_rst_lo_b",     {33'd0, lo_half, lo_b}, 64'd0);
        chk("mid_rst_lo_ready", {63'd0, lo_ready}, 64'd1);
        chk("mid_rst_hi_b",     {33'd0, hi_half, hi_b}, 64'd0);
        chk("mid_rst_hi_ready", {63'd0, hi_ready}, 64'd1);
        cycle();
        in_reset = 1'b1;
        rand_word(w_a);
        send(w_a);
        in_valid = 1'b0;
        chk("post_rst_lo_first", {33'd0, lo_half, lo_b}, {33'd0, beat_of(w_a, 1'b0)});
        repeat (3) cycle();

        // Random traffic with random backpressure; some words are followed by
        // a copy differing in one share-1 bit.
        rnd_rdy = 1'b1;
        for (int k = 0; k < 150; k++) begin
            rand_word(w_r);
            send(w_r);
            if (k % 10 == 0) begin
                w_r[1][$urandom_range(0, 29)] ^= 1'b1;
                send(w_r);
            end
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 2)) cycle();
            end
        end
        in_valid = 1'b0;
        rnd_rdy  = 1'b0;
        in_ready = 1'b1;
        n = 0;
        while (q_lo.size() != 0 && n < 20) begin
            cycle();
            n++;
        end
        cycle();
        chk("drain_lo_empty", 64'(q_lo.size()), 64'd0);
        chk("drain_hi_empty", 64'(q_hi.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
